vec_out_buffer: RTL and testbench

Output stage placed directly after the 2-lane sign-magnitude scaling multiplier. It takes the multiplier's two 16-bit sign-magnitude results (oX0/oX1 plus valid), converts them to two's complement and stores them in a first-word-fall-through FIFO. The FIFO lets a downstream consumer drain results under ready/valid flow control. The multiplier cannot be back-pressured, so the block reports loss through a sticky overflow flag and a saturating drop counter.

---
 rtl/vec_out_pkg.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 88 ++++++++
 rtl/vec_out_buffer.sv | 79 +++++++
 tb/tb_vec_out_buffer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vec_out_pkg.sv
// Shared types, sizes and the sign-magnitude to two's complement helper for
// the multiplier output buffer.
package vec_out_pkg;

  localparam int SM_W           = 16;
  localparam int TC_W           = 16;
  localparam int DEPTH_DEFAULT  = 16;
  localparam int DROP_W_DEFAULT = 8;

  // One FIFO entry: both lanes always travel together.
  typedef struct packed {
    logic [TC_W-1:0] x1;
    logic [TC_W-1:0] x0;
  } lane_pair_t;

  localparam int ENTRY_W = $bits(lane_pair_t);

  // Negative zero maps to 0, so 0x8000 can never be produced.
  function automatic logic [TC_W-1:0] sm_to_tc(input logic [SM_W-1:0] sm);
    logic [TC_W-1:0] mag;
    mag = {1'b0, sm[SM_W-2:0]};
    return sm[SM_W-1] ? (~mag + TC_W'(1)) : mag;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head entry is presented
// combinationally from memory; data is forced to zero while empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iWrValid,
  input  logic [WIDTH-1:0]         iWrData,
  output logic                     oWrAccept,
  output logic                     oRdValid,
  input  logic                     iRdReady,
  output logic [WIDTH-1:0]         oRdData,
  output logic [$clog2(DEPTH):0]   oLevel,
  output logic                     oFull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic valid;
  logic push;
  logic pop;

  // Handshake decode: a write into a full FIFO succeeds when a pop frees a slot.
  always_comb begin
    valid = (level_q != '0);
    pop   = valid && iRdReady;
    push  = iWrValid && ((level_q != LVL_MAX) || pop);
  end

  // Next-state for pointers, level and full flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_MAX);
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (iRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage write port.
  always_ff @(posedge iClk) begin
    // NOTE: the memory array has no reset; the empty-state output gating hides stale contents.
    if (push && !iRst) mem_q[wr_ptr_q] <= iWrData;
  end

  // Head presentation, gated to zero when empty.
  always_comb begin
    oRdData = valid ? mem_q[rd_ptr_q] : '0;
  end

  assign oWrAccept = push;
  assign oRdValid  = valid;
  assign oLevel    = level_q;
  assign oFull     = full_q;

endmodule

// File: rtl/vec_out_buffer.sv
// Output stage after the 2-lane sign-magnitude multiplier: converts both lanes
// to two's complement, buffers them in a FWFT FIFO and accounts for samples
// lost because the multiplier cannot be stalled.
module vec_out_buffer
  import vec_out_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DROP_W = DROP_W_DEFAULT
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iValid,
  input  logic [SM_W-1:0]        iX0,
  input  logic [SM_W-1:0]        iX1,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [TC_W-1:0]        oX0,
  output logic [TC_W-1:0]        oX1,
  output logic [$clog2(DEPTH):0] oLevel,
  output logic                   oFull,
  output logic                   oOverflow,
  output logic [DROP_W-1:0]      oDropCnt
);

  lane_pair_t wr_entry;
  lane_pair_t rd_entry;
  logic       accept;
  logic       drop;

  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Write-path conversion and lane packing.
  always_comb begin
    wr_entry.x0 = sm_to_tc(iX0);
    wr_entry.x1 = sm_to_tc(iX1);
  end

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iClk      (iClk),
    .iRst      (iRst),
    .iWrValid  (iValid),
    .iWrData   (wr_entry),
    .oWrAccept (accept),
    .oRdValid  (oValid),
    .iRdReady  (iReady),
    .oRdData   (rd_entry),
    .oLevel    (oLevel),
    .oFull     (oFull)
  );

  // Loss accounting: sticky flag plus saturating counter.
  always_comb begin
    drop       = iValid && !accept;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  // Loss accounting registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign oX0       = rd_entry.x0;
  assign oX1       = rd_entry.x1;
  assign oOverflow = overflow_q;
  assign oDropCnt  = drop_cnt_q;

endmodule

// File: tb/tb_vec_out_buffer.sv
// Self-checking bench for vec_out_buffer: table-driven conversion vectors,
// hand sequences for fill/drain/overflow/reset, and random streaming, all
// checked through a queue-based scoreboard.
module tb_vec_out_buffer;
  import vec_out_pkg::*;

  localparam int D = 16;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic [15:0] iX0, iX1;
  logic        oValid;
  logic        iReady;
  logic [15:0] oX0, oX1;
  logic [4:0]  oLevel;
  logic        oFull;
  logic        oOverflow;
  logic [7:0]  oDropCnt;

  vec_out_buffer #(.DEPTH(D), .DROP_W(8)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iX0       (iX0),
    .iX1       (iX1),
    .oValid    (oValid),
    .iReady    (iReady),
    .oX0       (oX0),
    .oX1       (oX1),
    .oLevel    (oLevel),
    .oFull     (oFull),
    .oOverflow (oOverflow),
    .oDropCnt  (oDropCnt)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];
  int          drops_m = 0;
  logic        ovf_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] sat_drops(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  // One clock cycle, entered and left just after a falling edge. The head is
  // compared against the scoreboard before the edge; registered status after.
  task automatic step(input logic v, input logic r, input logic [15:0] x0,
                      input logic [15:0] x1, input logic [31:0] exp);
    logic pop_m, push_m;
    iValid = v; iReady = r; iX0 = x0; iX1 = x1;
    #1;
    check("valid", {31'b0, oValid}, {31'b0, sb_q.size() != 0});
    if (sb_q.size() != 0) check("head", {oX1, oX0}, sb_q[0]);
    pop_m  = (sb_q.size() != 0) && r;
    push_m = v && ((sb_q.size() < D) || pop_m);
    if (pop_m) void'(sb_q.pop_front());
    if (push_m) sb_q.push_back(exp);
    else if (v) begin
      drops_m++;
      ovf_m = 1'b1;
    end
    @(posedge iClk);
    @(negedge iClk);
    check("level", {27'b0, oLevel}, 32'(sb_q.size()));
    check("full", {31'b0, oFull}, {31'b0, sb_q.size() == D});
    check("dropcnt", {24'b0, oDropCnt}, {24'b0, sat_drops(drops_m)});
    check("overflow", {31'b0, oOverflow}, {31'b0, ovf_m});
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'b0, oValid}, 32'd0);
    check({tag, "_level"}, {27'b0, oLevel}, 32'd0);
    check({tag, "_x"}, {oX1, oX0}, 32'd0);
    check({tag, "_ovf"}, {31'b0, oOverflow}, 32'd0);
    check({tag, "_drops"}, {24'b0, oDropCnt}, 32'd0);
    check({tag, "_full"}, {31'b0, oFull}, 32'd0);
  endtask

  // Values 1..16 on lane 0 positive, lane 1 negative.
  task automatic fill_ramp(input int base);
    for (int i = 1; i <= D; i++) begin
      logic [15:0] m;
      m = 16'(base + i);
      step(1'b1, 1'b0, m, m | 16'h8000, {16'(-int'(m)), m});
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 16'h0, 16'h0, 32'h0);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{x0: 16'h0005, x1: 16'h8005, e0: 16'h0005, e1: 16'hFFFB};
    tbl[1] = '{x0: 16'h8000, x1: 16'h7FFF, e0: 16'h0000, e1: 16'h7FFF};
    tbl[2] = '{x0: 16'hFFFF, x1: 16'h0000, e0: 16'h8001, e1: 16'h0000};
    tbl[3] = '{x0: 16'h8001, x1: 16'h0001, e0: 16'hFFFF, e1: 16'h0001};
    tbl[4] = '{x0: 16'h1234, x1: 16'h9234, e0: 16'h1234, e1: 16'hEDCC};

    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iX0 = '0; iX1 = '0;
    @(negedge iClk);
    iValid = 1'b1; iX0 = 16'h0003;
    @(negedge iClk);
    check_cleared("reset");
    iValid = 1'b0;
    iRst = 1'b0;
    @(negedge iClk);

    // Conversion: each entry is the head exactly one cycle after its push.
    foreach (tbl[i]) step(1'b1, 1'b1, tbl[i].x0, tbl[i].x1, {tbl[i].e1, tbl[i].e0});
    drain(2);

    // Fill then drain in order.
    fill_ramp(0);
    check("fill_full", {31'b0, oFull}, 32'd1);
    check("fill_level", {27'b0, oLevel}, 32'd16);
    drain(D);
    check("drained_valid", {31'b0, oValid}, 32'd0);
    check("drained_level", {27'b0, oLevel}, 32'd0);

    // Overflow: three drops while full.
    fill_ramp(0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0777, 16'h0777, 32'h07770777);
    check("ovf_flag", {31'b0, oOverflow}, 32'd1);
    check("ovf_cnt3", {24'b0, oDropCnt}, 32'd3);
    // Full with simultaneous pop: write accepted, no drop, level holds.
    step(1'b1, 1'b1, 16'h0063, 16'h8063, 32'hFF9D0063);
    check("fullpop_cnt", {24'b0, oDropCnt}, 32'd3);
    check("fullpop_level", {27'b0, oLevel}, 32'd16);
    for (int i = 0; i < 297; i++) step(1'b1, 1'b0, 16'h0555, 16'h0555, 32'h05550555);
    check("ovf_sat", {24'b0, oDropCnt}, 32'd255);
    // Contents 2..16 then the value written during the full pop.
    drain(D);

    // Reset mid-operation.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(i + 40), 16'(i + 40), {16'(i + 40), 16'(i + 40)});
    #2 iRst = 1'b1;
    #1 check_cleared("midrst");
    sb_q.delete(); drops_m = 0; ovf_m = 1'b0;
    iValid = 1'b1; iReady = 1'b1; iX0 = 16'h0011; iX1 = 16'h0022;
    @(posedge iClk); @(negedge iClk);
    check_cleared("rsthold");
    iRst = 1'b0;
    step(1'b1, 1'b0, 16'h8009, 16'h0009, 32'h0009FFF7);
    step(1'b0, 1'b1, 16'h0, 16'h0, 32'h0);

    // Random streaming.
    for (int c = 0; c < 10000; c++) begin
      logic [15:0] a, b;
      logic v, r;
      a = 16'($urandom);
      b = 16'($urandom);
      v = ($urandom_range(99) < 70);
      r = ($urandom_range(99) < 60);
      step(v, r, a, b, {sm_to_tc(b), sm_to_tc(a)});
    end
    drain(D + 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
